// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART on the MEM-stage data bus: TXD/RXD/CON registers,
// background serial transmit/receive and a registered level interrupt.
module mmio_uart #(
  parameter int unsigned BAUD_DIV  = 434,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        txd_q, txd_d;
  logic              uart_tx_q, uart_tx_d;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_armed_q, rx_armed_d;
  logic              rx_sync1_q, rx_sync1_d;
  logic              rx_sync2_q, rx_sync2_d;
  logic [7:0]        rxd_q, rxd_d;
  logic [1:0]        con_en_q, con_en_d;
  logic              tx_done_q, tx_done_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              irq_q, irq_d;

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic tx_busy, tx_done_set, rx_done_ok, rx_done_err;
  logic [6:0] con_value;
  logic unused_wdata;

  assign sel_txd   = (address == TXD_ADDR);
  assign sel_rxd   = (address == RXD_ADDR);
  assign sel_con   = (address == CON_ADDR);
  assign wr_txd    = write_enable & sel_txd;
  assign wr_con    = write_enable & sel_con;
  assign rd_rxd    = read_enable & sel_rxd;
  assign rd_con    = read_enable & sel_con;
  assign tx_busy   = (tx_state_q != TX_IDLE);
  assign con_value = {frame_err_q, rx_overrun_q, tx_busy, rx_valid_q, tx_done_q, con_en_q};
  assign uart_tx   = uart_tx_q;
  assign irq       = irq_q;
  assign unused_wdata = ^writedata[31:8];

  // Load data mux; zero unless a mapped register is being read.
  always_comb begin
    readdata = 32'd0;
    if (read_enable) begin
      if (sel_txd) begin
        readdata = {24'd0, txd_q};
      end else if (sel_rxd) begin
        readdata = {24'd0, rxd_q};
      end else if (sel_con) begin
        readdata = {25'd0, con_value};
      end else begin
        readdata = 32'd0;
      end
    end else begin
      readdata = 32'd0;
    end
  end

  // Transmit FSM: each state lasts BAUD_DIV cycles, data goes out LSB first.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    txd_d       = txd_q;
    uart_tx_d   = uart_tx_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        uart_tx_d = 1'b1;
        tx_cnt_d  = CW'(0);
        if (wr_txd) begin
          txd_d      = writedata[7:0];
          tx_state_d = TX_START;
          uart_tx_d  = 1'b0;
        end else begin
          txd_d = txd_q;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = CW'(0);
          tx_bit_d   = 3'd0;
          uart_tx_d  = txd_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_cnt_d = CW'(0);
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            uart_tx_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            uart_tx_d = txd_q[tx_bit_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BAUD_LAST) begin
          tx_state_d  = TX_IDLE;
          tx_cnt_d    = CW'(0);
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = CW'(0);
        uart_tx_d  = 1'b1;
      end
    endcase
  end

  // Receive FSM on the synchronised line; IDLE re-arms only after a high sample.
  always_comb begin
    rx_sync1_d  = uart_rx;
    rx_sync2_d  = rx_sync1_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_armed_d  = rx_armed_q;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CW'(0);
        if (!rx_armed_q) begin
          rx_armed_d = rx_sync2_q;
        end else if (!rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_armed_d = 1'b0;
        end else begin
          rx_armed_d = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = CW'(0);
          rx_bit_d = 3'd0;
          if (!rx_sync2_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = CW'(0);
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_LAST) begin
          rx_cnt_d   = CW'(0);
          rx_state_d = RX_IDLE;
          if (rx_sync2_q) begin
            rx_done_ok = 1'b1;
          end else begin
            rx_done_err = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CW'(0);
        rx_armed_d = 1'b0;
      end
    endcase
  end

  // Status flags: a set on the same edge as a clear-on-read wins.
  always_comb begin
    con_en_d     = wr_con ? writedata[1:0] : con_en_q;
    rxd_d        = rx_done_ok ? rx_shift_q : rxd_q;
    tx_done_d    = tx_done_set ? 1'b1 : (rd_con ? 1'b0 : tx_done_q);
    rx_valid_d   = rx_done_ok ? 1'b1 : (rd_rxd ? 1'b0 : rx_valid_q);
    rx_overrun_d = (rx_done_ok & rx_valid_q) ? 1'b1 : (rd_con ? 1'b0 : rx_overrun_q);
    frame_err_d  = rx_done_err ? 1'b1 : (rd_con ? 1'b0 : frame_err_q);
    irq_d        = (con_en_q[0] & tx_done_q) | (con_en_q[1] & rx_valid_q);
  end

  // State register for the whole peripheral.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= CW'(0);
      tx_bit_q     <= 3'd0;
      txd_q        <= 8'd0;
      uart_tx_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= CW'(0);
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_armed_q   <= 1'b0;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rxd_q        <= 8'd0;
      con_en_q     <= 2'd0;
      tx_done_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      txd_q        <= txd_d;
      uart_tx_q    <= uart_tx_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_armed_q   <= rx_armed_d;
      rx_sync1_q   <= rx_sync1_d;
      rx_sync2_q   <= rx_sync2_d;
      rxd_q        <= rxd_d;
      con_en_q     <= con_en_d;
      tx_done_q    <= tx_done_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART peripheral on the MEM-stage data bus. It sits beside data RAM, downstream of the EX/MEM register, and is selected by ALU address.
- Provides 8N1 transmit and receive, a status/control register, and a level IRQ output to the ID-stage control unit.
- Loads and stores complete in one cycle; serial activity runs in the background.

Parameters:
- BAUD_DIV, 434, clk cycles per serial bit (minimum 4).
- BASE_ADDR, 32'h40000018, address of TXD; RXD = BASE+4, CON = BASE+8.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  reset reset, asynchronous, active-high; clock clk
- read_enable  input  1  MEM-stage load strobe
- write_enable  input  1  MEM-stage store strobe
- address  input  32  byte address from ALUOUT_MEM
- writedata  input  32  store data
- readdata  output  32  load data, combinational
- uart_rx  input  1  serial in, asynchronous
- uart_tx  output  1  serial out, registered
- irq  output  1  interrupt request, registered

Behaviour:
- Reset: uart_tx=1, irq=0, readdata=0. TXD, RXD and CON are zero. TX FSM=IDLE, RX FSM=IDLE, counters=0.
- Decode: exact match of address[31:0] to the three addresses. Unmatched read gives readdata=0; unmatched write is ignored.
- readdata: {24'b0,TXD}, {24'b0,RXD} or {25'b0,CON[6:0]} when read_enable and matched, else 0.
- CON bits:
  - [0] TX_IRQ_EN (RW)
  - [1] RX_IRQ_EN (RW)
  - [2] TX_DONE (sticky, clear-on-read of CON)
  - [3] RX_VALID (RO, clear-on-read of RXD)
  - [4] TX_BUSY (RO)
  - [5] RX_OVERRUN (sticky, clear-on-read of CON)
  - [6] FRAME_ERR (sticky, clear-on-read of CON)
  - A CON write updates only bits [1:0].
- Read side effects take place at the clk edge where read_enable is high. Clear-on-read uses the value returned that cycle.
- Set wins over clear when both happen on the same edge: TX_DONE, RX_OVERRUN, FRAME_ERR and RX_VALID all stay 1, and the load returns the pre-edge value.
- irq is registered next cycle as (CON[0]&TX_DONE)|(CON[1]&RX_VALID).
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE. Each state holds BAUD_DIV cycles. Data is sent LSB first.
  - A write to TXD in IDLE latches writedata[7:0], sets TX_BUSY, and drives uart_tx=0 in the following cycle.
  - A write to TXD while TX_BUSY is ignored; TXD is unchanged.
  - At the end of STOP: TX_BUSY=0, TX_DONE=1. Total busy time is exactly 10*BAUD_DIV cycles.
- RX path: a 2-flop synchronizer on uart_rx feeds the FSM; this adds 2 cycles of latency.
  - IDLE: arms only after the synced line has been seen high. A falling (low) sample moves to START.
  - START: waits BAUD_DIV/2 cycles (integer). If still low -> DATA; if high -> IDLE (glitch reject, no flags).
  - DATA: samples every BAUD_DIV cycles, shifts in LSB first, 8 bits, then STOP.
  - STOP: samples after BAUD_DIV cycles.
    - High: RXD <= byte, RX_VALID=1. If RX_VALID was already 1, RX_OVERRUN=1 and the new byte overwrites.
    - Low: byte discarded, FRAME_ERR=1, RXD unchanged.
  - STOP always returns to IDLE, which waits for the line to be high.
- TX and RX are fully independent; a simultaneous load and store of different registers is not possible (single bus).
- Asynchronous reset mid-frame: uart_tx=1 immediately, both FSMs go to IDLE, the partial byte is lost.

Test Plan (BAUD_DIV=4):
- Store 0xA5 to 0x40000018 -> uart_tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1. CON[4]=1 during the frame. After 40 cycles CON reads 0x04, and an immediate second CON read returns 0x00.
- Store CON=0x01 then TXD=0x3C -> irq rises 1 cycle after TX_DONE is set. A CON read clears TX_DONE; irq falls the next cycle.
- Drive an 8N1 frame of 0x5A on uart_rx with CON=0x02 -> RXD reads 0x5A, CON[3]=1 and irq=1 until RXD is read; afterwards CON[3]=0 and irq=0.
- Two frames 0x11 then 0x22 with no RXD read -> RXD=0x22, CON reads 0x28, and a second CON read returns 0x08.
- Frame with stop bit 0, then a 1-cycle low glitch -> FRAME_ERR=1, RX_VALID=0, RXD unchanged. The glitch produces no flags.
- Store TXD=0x55 and, 2 cycles later, store TXD=0xFF -> the frame carries 0x55 only and TXD reads 0x55. Assert reset at bit 3 -> uart_tx=1 the same cycle and CON=0.
